// File: rtl/core_pipe_pkg.sv
// Shared state encoding and widths for the pipeline register slice.
// No logic; imported by the slice control and datapath.
package core_pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'b00,
        PS_HALF  = 2'b01,
        PS_FULL  = 2'b10
    } pipe_state_e;

    localparam int PIPE_COUNT_W = 2;

endpackage

// File: rtl/pipe_reg_ctrl.sv
// Occupancy FSM for the pipeline slice: decodes handshakes into data-entry load strobes.
// Latency 1 cycle in_fire->out_valid; in_ready registered when SKID=1, else ~out_valid|out_ready.
module pipe_reg_ctrl
    import core_pipe_pkg::*;
#(
    parameter bit SKID = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic                    out_ready,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [PIPE_COUNT_W-1:0] count,
    output logic                    load_main,
    output logic                    load_skid,
    output logic                    main_from_skid
);

    pipe_state_e r_state;
    pipe_state_e w_state_nxt;
    logic        w_in_fire;
    logic        w_out_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PS_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PS_EMPTY: begin
                if (w_in_fire) w_state_nxt = PS_HALF;
            end
            PS_HALF: begin
                if (SKID && w_in_fire && !w_out_fire)      w_state_nxt = PS_FULL;
                else if (!w_in_fire && w_out_fire)         w_state_nxt = PS_EMPTY;
            end
            PS_FULL: begin
                if (!SKID)          w_state_nxt = PS_EMPTY;
                else if (w_out_fire) w_state_nxt = PS_HALF;
            end
            default: w_state_nxt = PS_EMPTY;
        endcase
        // Flush wins over any transfer in the same cycle
        if (flush) w_state_nxt = PS_EMPTY;
    end

    always_comb begin
        out_valid = (r_state == PS_HALF) || (r_state == PS_FULL);
        case (r_state)
            PS_HALF: count = 2'd1;
            PS_FULL: count = 2'd2;
            default: count = 2'd0;
        endcase
        if (SKID) in_ready = (r_state != PS_FULL);
        else      in_ready = !out_valid || out_ready;
    end

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Loads are suppressed under flush so held data survives as the last visible value
    assign load_main      = w_in_fire & ~flush & (~out_valid | out_ready);
    assign load_skid      = SKID & w_in_fire & ~w_out_fire & ~flush & (r_state == PS_HALF);
    assign main_from_skid = SKID & w_out_fire & ~flush & (r_state == PS_FULL);

endmodule

// File: rtl/pipe_reg.sv
// Pipeline stage-boundary register with valid/ready, flush and optional skid entry; 1-cycle latency.
// Backpressure: SKID=1 registered in_ready at full rate, SKID=0 combinational in_ready.
module pipe_reg
    import core_pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               SKID        = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [PIPE_COUNT_W-1:0] count
);

    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;
    logic [WIDTH-1:0] w_skid;
    logic [WIDTH-1:0] r_main;

    pipe_reg_ctrl #(
        .SKID(SKID)
    ) u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .count          (count),
        .load_main      (w_load_main),
        .load_skid      (w_load_skid),
        .main_from_skid (w_main_from_skid)
    );

    generate
        if (SKID) begin : g_skid
            logic [WIDTH-1:0] r_skid;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_skid <= RESET_VALUE;
                end else if (w_load_skid) begin
                    r_skid <= in_data;
                end
            end
            assign w_skid = r_skid;
        end else begin : g_no_skid
            logic w_unused_skid;
            assign w_unused_skid = w_load_skid;
            assign w_skid        = RESET_VALUE;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main <= RESET_VALUE;
        end else if (w_main_from_skid) begin
            r_main <= w_skid;
        end else if (w_load_main) begin
            r_main <= in_data;
        end
    end

    assign out_data = r_main;

endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg: SKID=1 instance (reset value DEADBEEF) and SKID=0 instance.
// Expected payloads are queued at issue; negedge monitors pop and compare on each out_fire.
module tb_pipe_reg;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    // SKID=1 instance
    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_in_data, s_out_data;
    logic [1:0]  s_count;
    // SKID=0 instance
    logic        p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [31:0] p_in_data, p_out_data;
    logic [1:0]  p_count;

    logic [31:0] s_q[$];
    logic [31:0] p_q[$];

    pipe_reg #(.WIDTH(32), .RESET_VALUE(32'hDEAD_BEEF), .SKID(1'b1)) u_skid (
        .clk(clk), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .count(s_count)
    );

    pipe_reg #(.WIDTH(32), .RESET_VALUE(32'h0), .SKID(1'b0)) u_pass (
        .clk(clk), .reset(reset), .flush(p_flush),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .count(p_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && s_out_valid && s_out_ready) begin
            if (s_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL s_unexpected_out: got %h expected no payload", s_out_data);
            end else begin
                chk("s_out_data", s_out_data, s_q.pop_front());
            end
        end
        if (!reset && p_out_valid && p_out_ready) begin
            if (p_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL p_unexpected_out: got %h expected no payload", p_out_data);
            end else begin
                chk("p_out_data", p_out_data, p_q.pop_front());
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        s_flush = 0; s_in_valid = 0; s_in_data = 0; s_out_ready = 0;
        p_flush = 0; p_in_valid = 0; p_in_data = 0; p_out_ready = 0;
        tick;
        tick;
        reset = 1'b0;
        chk("rst_out_valid", {31'b0, s_out_valid}, 32'd0);
        chk("rst_count", {30'b0, s_count}, 32'd0);
        chk("rst_in_ready", {31'b0, s_in_ready}, 32'd1);
        chk("rst_out_data", s_out_data, 32'hDEAD_BEEF);
        chk("p_rst_in_ready", {31'b0, p_in_ready}, 32'd1);

        // SKID=0: combinational in_ready, no bubble
        p_in_valid = 1; p_in_data = 32'd4; p_q.push_back(32'd4);
        tick;
        p_in_valid = 0;
        #1;
        chk("p_stalled_in_ready", {31'b0, p_in_ready}, 32'd0);
        chk("p_count_half", {30'b0, p_count}, 32'd1);
        p_out_ready = 1; p_in_valid = 1; p_in_data = 32'd5; p_q.push_back(32'd5);
        #1;
        chk("p_pass_in_ready", {31'b0, p_in_ready}, 32'd1);
        tick;
        chk("p_pass_valid", {31'b0, p_out_valid}, 32'd1);
        chk("p_pass_data", p_out_data, 32'd5);
        p_in_valid = 0;
        tick;
        chk("p_drained", {31'b0, p_out_valid}, 32'd0);

        // SKID=1 streaming at full rate
        s_out_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            s_in_valid = 1; s_in_data = i; s_q.push_back(i);
            tick;
            chk("stream_count", {30'b0, s_count}, 32'd1);
            chk("stream_data", s_out_data, i);
        end
        s_in_valid = 0;
        tick;
        chk("stream_empty", {30'b0, s_count}, 32'd0);

        // Backpressure fills the skid entry
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 32'd10; s_q.push_back(32'd10);
        tick;
        s_in_data = 32'd11; s_q.push_back(32'd11);
        tick;
        s_in_valid = 0;
        chk("bp_count", {30'b0, s_count}, 32'd2);
        chk("bp_in_ready", {31'b0, s_in_ready}, 32'd0);
        chk("bp_data", s_out_data, 32'd10);
        tick;
        chk("bp_hold_data", s_out_data, 32'd10);
        chk("bp_hold_valid", {31'b0, s_out_valid}, 32'd1);
        s_out_ready = 1;
        tick;
        chk("bp_in_ready_after", {31'b0, s_in_ready}, 32'd1);
        chk("bp_count_after", {30'b0, s_count}, 32'd1);
        chk("bp_second_data", s_out_data, 32'd11);
        tick;
        chk("bp_empty", {30'b0, s_count}, 32'd0);

        // Flush while FULL with an offered payload: nothing survives
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 32'd20;
        tick;
        s_in_data = 32'd21;
        tick;
        chk("fl_full", {30'b0, s_count}, 32'd2);
        s_flush = 1; s_in_data = 32'd22;
        tick;
        s_flush = 0; s_in_valid = 0;
        chk("fl_valid", {31'b0, s_out_valid}, 32'd0);
        chk("fl_count", {30'b0, s_count}, 32'd0);
        chk("fl_data_kept", s_out_data, 32'd20);
        s_out_ready = 1;
        tick;
        tick;
        chk("fl_stays_empty", {31'b0, s_out_valid}, 32'd0);

        // Flush in HALF with a payload accepted the same cycle
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 32'd30;
        tick;
        s_flush = 1; s_in_data = 32'd31;
        tick;
        s_flush = 0; s_in_valid = 0;
        chk("fl_half_count", {30'b0, s_count}, 32'd0);
        s_out_ready = 1;
        tick;
        chk("fl_half_empty", {31'b0, s_out_valid}, 32'd0);

        // Flush coinciding with out_fire: delivered exactly once
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 32'd40; s_q.push_back(32'd40);
        tick;
        s_in_valid = 0; s_out_ready = 1; s_flush = 1;
        tick;
        s_flush = 0;
        chk("fl_fire_count", {30'b0, s_count}, 32'd0);
        tick;
        chk("fl_fire_empty", {31'b0, s_out_valid}, 32'd0);

        // Reset while FULL drops everything
        s_out_ready = 0;
        s_in_valid = 1; s_in_data = 32'd50;
        tick;
        s_in_data = 32'd51;
        tick;
        s_in_valid = 0;
        chk("mr_full", {30'b0, s_count}, 32'd2);
        reset = 1;
        tick;
        chk("mr_valid", {31'b0, s_out_valid}, 32'd0);
        chk("mr_count", {30'b0, s_count}, 32'd0);
        chk("mr_data", s_out_data, 32'hDEAD_BEEF);
        chk("mr_in_ready", {31'b0, s_in_ready}, 32'd1);
        reset = 0; s_out_ready = 1;
        tick;
        tick;
        chk("mr_no_stale", {31'b0, s_out_valid}, 32'd0);

        chk("s_queue_drained", s_q.size(), 32'd0);
        chk("p_queue_drained", p_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
Parametrised pipeline register slice for the core's inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Extends the plain enable-less data register with a valid/ready handshake, synchronous flush, a configurable reset value and an optional skid entry.
- The skid entry gives a fully registered in_ready at full throughput.
- Instantiated once per stage boundary; the stage payload is packed into data.

Parameters:
WIDTH, 32, payload width in bits (>=1)
RESET_VALUE, '0 (WIDTH bits), value loaded into both data entries on reset
SKID, 1, 1 = two-entry skid slice with registered in_ready; 0 = single-entry slice with combinational in_ready

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high; clock clk
flush  input  1  synchronous discard of all held entries (branch mispredict / trap)
in_valid  input  1  upstream payload valid
in_ready  output  1  slice can accept; transfer when in_valid & in_ready (in_fire)
in_data  input  WIDTH  upstream payload
out_valid  output  1  slice holds a payload for downstream
out_ready  input  1  downstream accepts; transfer when out_valid & out_ready (out_fire)
out_data  output  WIDTH  payload from the main entry
count  output  2  occupied entries: 0, 1, or 2 (2 only when SKID=1)

Behaviour:
- Storage: main entry (WIDTH), skid entry (WIDTH, SKID=1 only), 2-bit state register.
- States: EMPTY (0 entries), HALF (main valid), FULL (main + skid valid; SKID=1 only).
- out_valid = (state != EMPTY); out_data = main entry; count = number of occupied entries.
- Reset:
  - state <= EMPTY; main and skid <= RESET_VALUE.
  - Next cycle: out_valid=0, count=0, out_data=RESET_VALUE; in_ready=1.
  - Reset has priority over flush and all handshakes; reset mid-transfer drops all payloads.
- SKID=1:
  - in_ready = (state != FULL), decoded from the state register only; no combinational path from out_ready.
  - EMPTY: in_fire -> HALF, main <= in_data.
  - HALF, in_fire & out_fire -> HALF, main <= in_data.
  - HALF, in_fire & ~out_fire -> FULL, skid <= in_data.
  - HALF, ~in_fire & out_fire -> EMPTY.
  - HALF, neither -> hold.
  - FULL: out_fire -> HALF, main <= skid. No input accepted since in_ready=0.
  - Latency: in_fire to out_valid is 1 cycle. Sustains 1 transfer/cycle with out_ready held high.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - EMPTY: in_fire -> HALF, main <= in_data.
  - HALF: in_fire -> HALF with new data; out_fire & ~in_fire -> EMPTY.
  - FULL is unreachable. The skid entry is not implemented.
- Flush:
  - state <= EMPTY next cycle, regardless of in_fire/out_fire in the same cycle.
  - A payload accepted in the flush cycle is discarded.
  - A payload delivered downstream in the flush cycle counts as delivered; the downstream stage flushes it itself.
  - Data entries are not cleared by flush, so out_data keeps its last value while out_valid=0.
  - in_ready during the flush cycle follows the normal rule.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_valid hold.
- Downstream may drop out_ready at any time; upstream must hold in_data stable while in_valid & ~in_ready. The slice does not check this.
- Illegal state encoding (11) decodes as EMPTY on the next clock.

Decomposition:
- Package core_pipe_pkg: typedef enum logic [1:0] pipe_state_e {PS_EMPTY=2'b00, PS_HALF=2'b01, PS_FULL=2'b10}; localparam PIPE_COUNT_W = 2.
- One sub-module: pipe_reg_ctrl, the state FSM. Inputs: clk, reset, flush, in_valid, out_ready, parameter SKID. Outputs: in_ready, out_valid, count, load_main, load_skid, main_from_skid.
- pipe_reg instantiates pipe_reg_ctrl plus the data entries. The skid entry is generated only when SKID=1.

Test Plan:
- Reset: WIDTH=32, RESET_VALUE=32'hDEAD_BEEF, reset high 2 cycles -> out_valid=0, count=0, in_ready=1, out_data=32'hDEAD_BEEF.
- Streaming, SKID=1: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_data 1,2,3,4 one cycle later each, 1/cycle, count stays 1.
- Backpressure, SKID=1:
  - Push 10 and 11 with out_ready=0 -> count=2, in_ready=0, out_data=10.
  - Raise out_ready -> 10 then 11 delivered on consecutive cycles; in_ready=1 the cycle after the first out_fire.
- SKID=0 pass-through: out_valid=1, out_ready=1, in_valid=1 data 5 -> in_ready=1 same cycle; out_data=5 next cycle, no bubble.
- Flush:
  - State FULL (20, 21); assert flush with in_valid=1 data 22 and out_ready=0 -> next cycle out_valid=0, count=0; 20/21/22 never appear as valid.
  - Flush with out_fire in the same cycle -> the delivered payload counts once.
- Reset mid-operation: FULL with out_ready=0; assert reset -> next cycle EMPTY, out_data=RESET_VALUE, no stale payload after deassert.
